// File: rtl/spi_mem_sched.sv
// spi_mem_sched: decodes SPI command frames, buffers one SPI memory command,
// and round-robin arbitrates a single-port synchronous RAM between the SPI
// path and a local host port.
module spi_mem_sched #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [9:0]        rx_data,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              spi_ovf,
  output logic              seq_err,
  output logic              busy
);

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RDATA  = 2'd2
  } state_e;

  state_e              state_q;

  // Address registers and the one-entry SPI pending buffer
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic                rd_addr_vld_q;
  logic                spi_pend_q;
  logic                pend_we_q;
  logic [ADDR_W-1:0]   pend_addr_q;
  logic [DATA_W-1:0]   pend_wdata_q;
  logic                last_spi_q;
  logic                own_spi_q;

  // Registered outputs
  logic                tx_valid_q;
  logic [DATA_W-1:0]   tx_data_q;
  logic                host_gnt_q;
  logic                host_rvalid_q;
  logic [DATA_W-1:0]   host_rdata_q;
  logic                mem_en_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                spi_ovf_q;
  logic                seq_err_q;

  logic [1:0]          cmd_c;
  logic                mem_cmd_c;
  logic                seq_err_c;
  logic                idle_c;
  logic                grant_spi_c;
  logic                grant_host_c;

  // Frame decode and arbitration decisions for the current cycle
  assign cmd_c        = rx_data[9:8];
  assign mem_cmd_c    = rx_valid && ((cmd_c == CMD_WR_DATA) ||
                                     ((cmd_c == CMD_RD_DATA) && rd_addr_vld_q));
  assign seq_err_c    = rx_valid && (cmd_c == CMD_RD_DATA) && !rd_addr_vld_q;
  assign idle_c       = (state_q == S_IDLE);
  assign grant_spi_c  = idle_c && spi_pend_q && (!host_req || !last_spi_q);
  assign grant_host_c = idle_c && host_req && !grant_spi_c;

  // Address registers, pending buffer load/drop and error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      rd_addr_vld_q <= 1'b0;
      spi_pend_q    <= 1'b0;
      pend_we_q     <= 1'b0;
      pend_addr_q   <= '0;
      pend_wdata_q  <= '0;
      spi_ovf_q     <= 1'b0;
      seq_err_q     <= 1'b0;
    end else begin
      spi_ovf_q <= 1'b0;
      seq_err_q <= seq_err_c;
      if (rx_valid && (cmd_c == CMD_WR_ADDR)) begin
        wr_addr_q <= ADDR_W'(rx_data[7:0]);
      end
      if (rx_valid && (cmd_c == CMD_RD_ADDR)) begin
        rd_addr_q     <= ADDR_W'(rx_data[7:0]);
        rd_addr_vld_q <= 1'b1;
      end
      if (grant_spi_c) begin
        spi_pend_q <= 1'b0;
      end
      // A slot is free if empty or being issued this very cycle
      if (mem_cmd_c) begin
        if (spi_pend_q && !grant_spi_c) begin
          spi_ovf_q <= 1'b1;
        end else begin
          spi_pend_q   <= 1'b1;
          pend_we_q    <= (cmd_c == CMD_WR_DATA);
          pend_addr_q  <= (cmd_c == CMD_WR_DATA) ? wr_addr_q : rd_addr_q;
          pend_wdata_q <= DATA_W'(rx_data[7:0]);
        end
      end
    end
  end

  // Access FSM: IDLE grants, ACCESS drives the RAM for one cycle, RDATA returns data
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      last_spi_q    <= 1'b0;
      own_spi_q     <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
      host_gnt_q    <= 1'b0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      host_gnt_q    <= 1'b0;
      host_rvalid_q <= 1'b0;
      // Any new frame clears tx_valid; a set later in this block overrides it
      if (rx_valid) begin
        tx_valid_q <= 1'b0;
      end
      if (seq_err_c) begin
        tx_data_q  <= '0;
        tx_valid_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (grant_spi_c) begin
            mem_en_q    <= 1'b1;
            mem_we_q    <= pend_we_q;
            mem_addr_q  <= pend_addr_q;
            mem_wdata_q <= pend_wdata_q;
            own_spi_q   <= 1'b1;
            last_spi_q  <= 1'b1;
            state_q     <= S_ACCESS;
          end else if (grant_host_c) begin
            mem_en_q    <= 1'b1;
            mem_we_q    <= host_we;
            mem_addr_q  <= host_addr;
            mem_wdata_q <= host_wdata;
            host_gnt_q  <= 1'b1;
            own_spi_q   <= 1'b0;
            last_spi_q  <= 1'b0;
            state_q     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          state_q  <= mem_we_q ? S_IDLE : S_RDATA;
        end
        S_RDATA: begin
          if (own_spi_q) begin
            tx_data_q  <= mem_rdata;
            tx_valid_q <= 1'b1;
          end else begin
            host_rdata_q  <= mem_rdata;
            host_rvalid_q <= 1'b1;
          end
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign host_gnt    = host_gnt_q;
  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_q;
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign spi_ovf     = spi_ovf_q;
  assign seq_err     = seq_err_q;
  assign busy        = (state_q != S_IDLE) || spi_pend_q;

endmodule
